mem_stage: RTL
==============

# mem_stage

Memory-access stage of the 32-bit MIPS pipeline, directly downstream of Execute. Registers the Execute outputs (ALU result, store operand, next-PC selection), performs byte/half/word loads and stores against an internal byte-enabled synchronous data RAM, and presents a registered write-back bundle plus the resolved next PC. Loads stall Execute for one cycle through a valid/ready handshake.

## Interface
- DEPTH_WORDS, 256, data RAM depth in 32-bit words (power of two)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  Execute presents a valid instruction
- ex_ready  out  1  stage accepts this cycle; transfer when ex_valid && ex_ready
- alu_result  in  32  ALU result / effective address
- store_data  in  32  second register operand, store source
- next_pc  in  32  branch-mux output from Execute
- mem_read, mem_write  in  1 each  load / store request
- mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- mem_unsigned  in  1  zero-extend loads when 1
- reg_write  in  1  instruction writes a register
- write_reg  in  5  destination register
- wb_valid  out  1  write-back bundle valid (one-cycle pulse per instruction)
- wb_we  out  1  register write enable (qualified by wb_valid)
- wb_reg  out  5  destination register
- wb_data  out  32  load data or passed-through alu_result
- pc_out  out  32  registered next_pc of the retiring instruction
- fault  out  1  one-cycle pulse: misaligned access, reserved size, or read&&write

## Operation
- FSM states: IDLE, LOAD. ex_ready = (state == IDLE).
- IDLE, transfer, no memory op: capture fields; next cycle wb_valid=1, wb_data=alu_result, wb_we=reg_write.
- IDLE, transfer, store: RAM written on the accepting edge with lane enables; next cycle wb_valid=1, wb_we=0.
- IDLE, transfer, load: capture address/size/sign, go LOAD; RAM read issued; at end of LOAD the extended result is registered, wb_valid=1 next cycle, wb_we=reg_write, state returns to IDLE.
- Word index = alu_result[log2(DEPTH_WORDS)+1:2]; upper address bits ignored (wrap).
- Lanes little-endian: byte lane = addr[1:0]; half lanes = {addr[1],1}/{addr[1],0}. Store replicates store_data[7:0]/[15:0] into selected lanes.
- Load extension: byte/half sign-extended unless mem_unsigned; word unchanged.
- Faults (half with addr[0]=1, word with addr[1:0]!=0, mem_size=11 with a memory op, mem_read&&mem_write): no RAM access, no LOAD state, fault=1 and wb_valid=1 with wb_we=0 next cycle.
- pc_out updates with every retiring instruction, including faulting ones.
- ex_valid while ex_ready=0 is ignored; Execute holds its outputs.

## Timing
- Reset: state IDLE, ex_ready=1 after reset cycle, wb_valid=0, wb_we=0, wb_reg=0, wb_data=0, pc_out=0, fault=0. RAM contents not cleared.
- Latency: non-memory and store 1 cycle (accept edge N -> wb_valid high in cycle after N); load 2 cycles (wb_valid in cycle after N+1).
- Throughput: 1/cycle for non-loads; back-to-back loads 1 per 2 cycles.
- Store followed by load to same word in next accepted cycle returns the new data (write completes at accept edge).
- rst during LOAD: load discarded, wb_valid=0 in cycle after reset, state IDLE.
- wb_valid/fault are single-cycle pulses; outputs other than pulses hold until next retirement.

## Structure
- Shared package mips_pkg: mem_size encodings (MS_BYTE, MS_HALF, MS_WORD), stage state enum, DATA_W=32.
- One sub-module: data_ram — DEPTH_WORDS x 32, 4 byte write enables, synchronous read with registered output, no reset.
- Lane-enable/replication and load extension as combinational logic inside mem_stage.

## Test plan
- Non-memory op alu_result=0x0000_1234, reg_write=1, write_reg=5 -> next cycle wb_valid=1, wb_we=1, wb_reg=5, wb_data=0x0000_1234, ex_ready stays 1.
- Store word 0xDEADBEEF at 0x40, then load word 0x40 -> load wb_data=0xDEADBEEF two cycles after accept; ex_ready=0 for exactly one cycle.
- Store byte 0x80 at 0x43, load byte signed 0x43 -> 0xFFFF_FF80; load byte unsigned -> 0x0000_0080; load word 0x40 -> 0x80ADBEEF.
- Load half at 0x41 -> fault=1 one cycle, wb_valid=1, wb_we=0, RAM unchanged; mem_read&&mem_write -> same fault response.
- Address 0x0000_0400 with DEPTH_WORDS=256 aliases word 0: store there, load 0x0 returns same value.
- Assert rst during LOAD -> no wb_valid, ex_ready=1 in cycle after reset, all outputs at reset values.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: data width, memory access size codes,
// memory-stage state encoding and the access fault rule.
package mips_pkg;

   localparam int unsigned DATA_W = 32;

   localparam logic [1:0] MS_BYTE = 2'b00;
   localparam logic [1:0] MS_HALF = 2'b01;
   localparam logic [1:0] MS_WORD = 2'b10;
   localparam logic [1:0] MS_RSVD = 2'b11;

   typedef enum logic [0:0] {
      StIdle,
      StLoad
   } stage_state_e;

   // An access faults when it is both a read and a write, uses the reserved size,
   // or is not naturally aligned. Non-memory instructions never fault.
   function automatic logic access_fault(input logic       rd,
                                         input logic       wr,
                                         input logic [1:0] size,
                                         input logic [1:0] off);
      logic f;
      f = 1'b0;
      if (rd || wr) begin
         if (rd && wr)                             f = 1'b1;
         if (size == MS_RSVD)                      f = 1'b1;
         if (size == MS_HALF && off[0])            f = 1'b1;
         if (size == MS_WORD && off != 2'b00)      f = 1'b1;
      end
      return f;
   endfunction

endpackage

// File: rtl/data_ram.sv
// Byte-enabled single-port data RAM with synchronous, registered read port.
module data_ram
   import mips_pkg::*;
#(
   parameter  int unsigned DEPTH_WORDS = 256,
   localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
   input  logic              clk_i,
   input  logic              re_i,
   input  logic [3:0]        we_i,
   input  logic [AW-1:0]     addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < 4; i++) begin
         if (we_i[i]) begin
            mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
         end
      end
      if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: registers Execute outputs, performs byte/half/word
// loads and stores on the data RAM and presents a registered write-back bundle.
module mem_stage
   import mips_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              ex_valid_i,
   output logic              ex_ready_o,
   input  logic [DATA_W-1:0] alu_result_i,
   input  logic [DATA_W-1:0] store_data_i,
   input  logic [DATA_W-1:0] next_pc_i,
   input  logic              mem_read_i,
   input  logic              mem_write_i,
   input  logic [1:0]        mem_size_i,
   input  logic              mem_unsigned_i,
   input  logic              reg_write_i,
   input  logic [4:0]        write_reg_i,
   output logic              wb_valid_o,
   output logic              wb_we_o,
   output logic [4:0]        wb_reg_o,
   output logic [DATA_W-1:0] wb_data_o,
   output logic [DATA_W-1:0] pc_out_o,
   output logic              fault_o
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   stage_state_e state_q, state_d;

   logic              wb_valid_q, wb_valid_d;
   logic              wb_we_q, wb_we_d;
   logic [4:0]        wb_reg_q, wb_reg_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic [DATA_W-1:0] pc_q, pc_d;
   logic              fault_q, fault_d;

   // Load context held across the RAM read cycle.
   logic [1:0]        ld_off_q, ld_off_d;
   logic [1:0]        ld_size_q, ld_size_d;
   logic              ld_uns_q, ld_uns_d;
   logic              ld_we_q, ld_we_d;
   logic [4:0]        ld_reg_q, ld_reg_d;
   logic [DATA_W-1:0] ld_pc_q, ld_pc_d;

   logic              accept;
   logic              acc_fault;
   logic              ram_re;
   logic [3:0]        ram_we;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [DATA_W-1:0] ld_ext;
   logic              unused_addr_hi;

   assign ex_ready_o = (state_q == StIdle);
   assign accept     = ex_valid_i && ex_ready_o;
   assign acc_fault  = access_fault(mem_read_i, mem_write_i, mem_size_i, alu_result_i[1:0]);
   assign ram_re     = accept && mem_read_i && !acc_fault;

   // Upper address bits wrap onto the RAM.
   assign unused_addr_hi = ^alu_result_i[DATA_W-1:AW+2];

   always_comb begin
      ram_we    = 4'b0000;
      ram_wdata = store_data_i;
      if (accept && mem_write_i && !acc_fault) begin
         case (mem_size_i)
            MS_BYTE: begin
               ram_we    = 4'b0001 << alu_result_i[1:0];
               ram_wdata = {4{store_data_i[7:0]}};
            end
            MS_HALF: begin
               ram_we    = alu_result_i[1] ? 4'b1100 : 4'b0011;
               ram_wdata = {2{store_data_i[15:0]}};
            end
            default: ram_we = 4'b1111;
         endcase
      end
   end

   data_ram #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_data_ram (
      .clk_i   (clk_i),
      .re_i    (ram_re),
      .we_i    (ram_we),
      .addr_i  (alu_result_i[AW+1:2]),
      .wdata_i (ram_wdata),
      .rdata_o (ram_rdata)
   );

   always_comb begin
      ld_byte = ram_rdata[7:0];
      case (ld_off_q)
         2'd1:    ld_byte = ram_rdata[15:8];
         2'd2:    ld_byte = ram_rdata[23:16];
         2'd3:    ld_byte = ram_rdata[31:24];
         default: ld_byte = ram_rdata[7:0];
      endcase
      ld_half = ld_off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
      case (ld_size_q)
         MS_BYTE: ld_ext = {{24{~ld_uns_q & ld_byte[7]}}, ld_byte};
         MS_HALF: ld_ext = {{16{~ld_uns_q & ld_half[15]}}, ld_half};
         default: ld_ext = ram_rdata;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      wb_valid_d = 1'b0;
      fault_d    = 1'b0;
      wb_we_d    = wb_we_q;
      wb_reg_d   = wb_reg_q;
      wb_data_d  = wb_data_q;
      pc_d       = pc_q;
      ld_off_d   = ld_off_q;
      ld_size_d  = ld_size_q;
      ld_uns_d   = ld_uns_q;
      ld_we_d    = ld_we_q;
      ld_reg_d   = ld_reg_q;
      ld_pc_d    = ld_pc_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (acc_fault) begin
                  wb_valid_d = 1'b1;
                  fault_d    = 1'b1;
                  wb_we_d    = 1'b0;
                  wb_reg_d   = write_reg_i;
                  wb_data_d  = alu_result_i;
                  pc_d       = next_pc_i;
               end else if (mem_read_i) begin
                  state_d   = StLoad;
                  ld_off_d  = alu_result_i[1:0];
                  ld_size_d = mem_size_i;
                  ld_uns_d  = mem_unsigned_i;
                  ld_we_d   = reg_write_i;
                  ld_reg_d  = write_reg_i;
                  ld_pc_d   = next_pc_i;
               end else begin
                  wb_valid_d = 1'b1;
                  wb_we_d    = reg_write_i && !mem_write_i;
                  wb_reg_d   = write_reg_i;
                  wb_data_d  = alu_result_i;
                  pc_d       = next_pc_i;
               end
            end
         end
         StLoad: begin
            state_d    = StIdle;
            wb_valid_d = 1'b1;
            wb_we_d    = ld_we_q;
            wb_reg_d   = ld_reg_q;
            wb_data_d  = ld_ext;
            pc_d       = ld_pc_q;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         wb_valid_q <= 1'b0;
         wb_we_q    <= 1'b0;
         wb_reg_q   <= '0;
         wb_data_q  <= '0;
         pc_q       <= '0;
         fault_q    <= 1'b0;
         ld_off_q   <= '0;
         ld_size_q  <= '0;
         ld_uns_q   <= 1'b0;
         ld_we_q    <= 1'b0;
         ld_reg_q   <= '0;
         ld_pc_q    <= '0;
      end else begin
         state_q    <= state_d;
         wb_valid_q <= wb_valid_d;
         wb_we_q    <= wb_we_d;
         wb_reg_q   <= wb_reg_d;
         wb_data_q  <= wb_data_d;
         pc_q       <= pc_d;
         fault_q    <= fault_d;
         ld_off_q   <= ld_off_d;
         ld_size_q  <= ld_size_d;
         ld_uns_q   <= ld_uns_d;
         ld_we_q    <= ld_we_d;
         ld_reg_q   <= ld_reg_d;
         ld_pc_q    <= ld_pc_d;
      end
   end

   assign wb_valid_o = wb_valid_q;
   assign wb_we_o    = wb_we_q;
   assign wb_reg_o   = wb_reg_q;
   assign wb_data_o  = wb_data_q;
   assign pc_out_o   = pc_q;
   assign fault_o    = fault_q;

endmodule
